// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: op codes, field widths,
// request record, FSM state encoding and word-building helpers.
package instr_encoder_pkg;

    localparam int OP_W     = 4;
    localparam int REG_W    = 4;
    localparam int IMM_W    = 4;
    localparam int OPCODE_W = 8;
    localparam int INSTR_W  = OPCODE_W + 2 * REG_W;
    localparam int VAL_W    = 16;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [OP_W-1:0] OP_SUBI  = 4'd3;
    localparam logic [OP_W-1:0] OP_CMP   = 4'd4;
    localparam logic [OP_W-1:0] OP_CMPI  = 4'd5;
    localparam logic [OP_W-1:0] OP_AND   = 4'd6;
    localparam logic [OP_W-1:0] OP_ANDI  = 4'd7;
    localparam logic [OP_W-1:0] OP_OR    = 4'd8;
    localparam logic [OP_W-1:0] OP_ORI   = 4'd9;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd10;
    localparam logic [OP_W-1:0] OP_XORI  = 4'd11;
    localparam logic [OP_W-1:0] OP_MOV   = 4'd12;
    localparam logic [OP_W-1:0] OP_MOVI  = 4'd13;
    localparam logic [OP_W-1:0] OP_LSHI  = 4'd14;
    localparam logic [OP_W-1:0] OP_LDI16 = 4'd15;

    // State names the word currently presented on the output register.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LDI_MOV = 2'd1,
        ST_LDI_SHL = 2'd2,
        ST_LDI_OR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rdst;
        logic [REG_W-1:0] rsrc;
        logic [VAL_W-1:0] imm;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    function automatic logic is_imm_form(input logic [OP_W-1:0] op);
        return op[0] || (op == OP_LSHI);
    endfunction

    function automatic logic [INSTR_W-1:0] make_word(input logic [OP_W-1:0]  op,
                                                     input logic [REG_W-1:0] a,
                                                     input logic [REG_W-1:0] b);
        return {{(OPCODE_W-OP_W){1'b0}}, op, a, b};
    endfunction

endpackage

// File: rtl/instr_encoder_req_fifo.sv
// Request buffer: synchronous FIFO with occupancy count and full/empty flags.
// A push while full is dropped, a pop while empty is ignored.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes buffered ALU requests into {opcode,A,B}+imm words and expands LDI16
// into MOVI/LSHI/ORI. Optional macro LDI_SKIP_ZERO_EN drops ORI of zero nibbles.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LDI_SHIFT  = 4
) (
    input  logic               Clock,
    input  logic               reset,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the source holds its payload until then, the sink may stall via ready.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    req_op,
    input  logic [REG_W-1:0]   req_rdst,
    input  logic [REG_W-1:0]   req_rsrc,
    input  logic [VAL_W-1:0]   req_imm,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [IMM_W-1:0]   imm,
    output logic               busy,
    output state_t             dbg_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IMM_W-1:0] SHIFT_IMM = IMM_W'(LDI_SHIFT);

    req_t              push_data;
    req_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_count;

    state_t            state_q;
    logic [1:0]        s_q;
    logic [REG_W-1:0]  rdst_q;
    logic [11:0]       v_q;
    logic              valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [IMM_W-1:0]  imm_q;

    logic              advance;
    logic [IMM_W-1:0]  nib;
    logic              skip_or;
    logic              seq_done;
    logic              head_imm_form;
    logic [INSTR_W-1:0] head_word;
    logic [IMM_W-1:0]  head_imm;
    logic [INSTR_W-1:0] lshi_word;
    logic [INSTR_W-1:0] ori_word;

    assign push_data = '{op: req_op, rdst: req_rdst, rsrc: req_rsrc, imm: req_imm};

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i   (Clock),
        .rst_i   (reset),
        .push_i  (req_valid),
        .wdata_i (push_data),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign req_ready = !fifo_full;
    assign advance   = !valid_q || instr_ready;

    always_comb begin
        case (s_q)
            2'd0:    nib = v_q[3:0];
            2'd1:    nib = v_q[7:4];
            default: nib = v_q[11:8];
        endcase
    end

`ifdef LDI_SKIP_ZERO_EN
    assign skip_or = (nib == '0);
`else
    assign skip_or = 1'b0;
`endif

    // The last word of an LDI16 is leaving, so the next request may follow
    // on the same edge without a bubble.
    assign seq_done = ((state_q == ST_LDI_OR) && (s_q == 2'd0)) ||
                      ((state_q == ST_LDI_SHL) && skip_or && (s_q == 2'd0));
    assign fifo_pop = advance && !fifo_empty && ((state_q == ST_IDLE) || seq_done);

    assign head_imm_form = is_imm_form(head.op);
    assign head_word     = make_word(head.op, head.rdst, head_imm_form ? '0 : head.rsrc);
    assign head_imm      = head_imm_form ? head.imm[IMM_W-1:0] : '0;
    assign lshi_word     = make_word(OP_LSHI, rdst_q, '0);
    assign ori_word      = make_word(OP_ORI, rdst_q, '0);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            rdst_q  <= '0;
            v_q     <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
        end else if (advance) begin
            if (fifo_pop) begin
                valid_q <= 1'b1;
                if (head.op == OP_LDI16) begin
                    state_q <= ST_LDI_MOV;
                    rdst_q  <= head.rdst;
                    v_q     <= head.imm[11:0];
                    instr_q <= make_word(OP_MOVI, head.rdst, '0);
                    imm_q   <= head.imm[15:12];
                end else begin
                    state_q <= ST_IDLE;
                    instr_q <= head_word;
                    imm_q   <= head_imm;
                end
            end else begin
                case (state_q)
                    ST_LDI_MOV: begin
                        s_q     <= 2'd2;
                        instr_q <= lshi_word;
                        imm_q   <= SHIFT_IMM;
                        state_q <= ST_LDI_SHL;
                    end
                    ST_LDI_SHL: begin
                        if (!skip_or) begin
                            instr_q <= ori_word;
                            imm_q   <= nib;
                            state_q <= ST_LDI_OR;
                        end else if (s_q != 2'd0) begin
                            s_q     <= s_q - 2'd1;
                            instr_q <= lshi_word;
                            imm_q   <= SHIFT_IMM;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_LDI_OR: begin
                        if (s_q != 2'd0) begin
                            s_q     <= s_q - 2'd1;
                            instr_q <= lshi_word;
                            imm_q   <= SHIFT_IMM;
                            state_q <= ST_LDI_SHL;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign imm         = imm_q;
    assign busy        = valid_q || (state_q != ST_IDLE) || (fifo_count != '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic against a queue-based reference model of the encoding rules.
module tb_instr_encoder;

    logic        Clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [3:0]  req_rdst;
    logic [3:0]  req_rsrc;
    logic [15:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [3:0]  imm;
    logic        busy;
    instr_encoder_pkg::state_t dbg_state;

`ifdef LDI_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    int tests_run = 0;
    int failed    = 0;
    logic [19:0] exp_q[$];

    instr_encoder #(
        .FIFO_DEPTH (4),
        .LDI_SHIFT  (4)
    ) dut (
        .Clock       (Clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rdst    (req_rdst),
        .req_rsrc    (req_rsrc),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .imm         (imm),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: expected {instruction, imm} words for one accepted request.
    task automatic model_push(input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] rs, input logic [15:0] v);
        logic [3:0] n;
        if (op != 4'd15) begin
            if (op[0] || op == 4'd14) exp_q.push_back({4'h0, op, rd, 4'h0, v[3:0]});
            else                      exp_q.push_back({4'h0, op, rd, rs, 4'h0});
        end else begin
            exp_q.push_back({8'h0D, rd, 4'h0, v[15:12]});
            for (int i = 2; i >= 0; i--) begin
                exp_q.push_back({8'h0E, rd, 4'h0, 4'd4});
                n = 4'((v >> (4 * i)) & 16'hF);
                if (!SKIP_ZERO || n != 4'h0) exp_q.push_back({8'h09, rd, 4'h0, n});
            end
        end
    endtask

    // One clock: sample handshakes before the edge, feed accepted requests to the model.
    task automatic tick(output logic acc, output logic cons, output logic [19:0] word);
        acc  = req_valid && req_ready;
        cons = instr_valid && instr_ready;
        word = {instruction, imm};
        if (acc) model_push(req_op, req_rdst, req_rsrc, req_imm);
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [15:0] v);
        req_valid = 1'b1;
        req_op    = op;
        req_rdst  = rd;
        req_rsrc  = rs;
        req_imm   = v;
    endtask

    // Holds a request until accepted; used only while instr_ready is low.
    task automatic push_req(input logic [3:0] op, input logic [3:0] rd,
                            input logic [3:0] rs, input logic [15:0] v);
        logic acc, cons;
        logic [19:0] w;
        bit done = 0;
        set_req(op, rd, rs, v);
        for (int i = 0; i < 50 && !done; i++) begin
            tick(acc, cons, w);
            done = acc;
        end
        req_valid = 1'b0;
        if (!done) begin
            tests_run++;
            failed++;
            $display("FAIL push_timeout: got not accepted want accepted op=%0d", op);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = '0; req_rdst = '0; req_rsrc = '0; req_imm = '0;
        instr_ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        tests_run++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        tests_run++; if (instruction !== 16'h0000) begin failed++; $display("FAIL reset_instr: got %h want 0000", instruction); end
        tests_run++; if (imm !== 4'h0) begin failed++; $display("FAIL reset_imm: got %h want 0", imm); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        tests_run++; if (dbg_state !== instr_encoder_pkg::ST_IDLE) begin failed++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_single_add;
        logic acc, cons;
        logic [19:0] w, e;
        exp_q.delete();
        instr_ready = 1'b1;
        set_req(4'd0, 4'd3, 4'd5, 16'($urandom));
        tick(acc, cons, w);
        req_valid = 1'b0;
        tests_run++; if (acc !== 1'b1) begin failed++; $display("FAIL add_accept: got %b want 1", acc); end
        tests_run++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL add_latency_early: got %b want 0", instr_valid); end
        tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL add_busy: got %b want 1", busy); end
        tick(acc, cons, w);
        tests_run++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL add_latency: got %b want 1", instr_valid); end
        tests_run++; if ({instruction, imm} !== 20'h00350) begin failed++; $display("FAIL add_word: got %h want 00350", {instruction, imm}); end
        tick(acc, cons, w);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
        tests_run++; if (!cons || w !== e) begin failed++; $display("FAIL add_consume: got cons=%b %h want cons=1 %h", cons, w, e); end
        tests_run++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL add_idle: got valid=%b busy=%b want 0 0", instr_valid, busy); end
    endtask

    task automatic test_hold;
        logic acc, cons;
        logic [19:0] w, e;
        exp_q.delete();
        instr_ready = 1'b0;
        set_req(4'd1, 4'd2, 4'($urandom), 16'h0009);
        tick(acc, cons, w);
        req_valid = 1'b0;
        tick(acc, cons, w);
        e = (exp_q.size() > 0) ? exp_q[0] : 20'hxxxxx;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (instr_valid !== 1'b1 || {instruction, imm} !== 20'h01209) begin
                failed++;
                $display("FAIL hold_stable[%0d]: got v=%b %h want v=1 01209", i, instr_valid, {instruction, imm});
            end
            tick(acc, cons, w);
        end
        instr_ready = 1'b1;
        tick(acc, cons, w);
        if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
        tests_run++; if (!cons || w !== e) begin failed++; $display("FAIL hold_consume: got cons=%b %h want cons=1 %h", cons, w, e); end
        tests_run++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL hold_after: got %b want 0", instr_valid); end
    endtask

    task automatic test_fifo_full;
        logic acc, cons;
        logic [19:0] w, e;
        bit got5 = 0;
        exp_q.delete();
        instr_ready = 1'b0;
        push_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 16'($urandom));
        tick(acc, cons, w);
        for (int i = 0; i < 4; i++) begin
            set_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 16'($urandom));
            tick(acc, cons, w);
            tests_run++; if (acc !== 1'b1) begin failed++; $display("FAIL full_fill[%0d]: got acc=%b want 1", i, acc); end
        end
        set_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (req_ready !== 1'b0) begin failed++; $display("FAIL full_ready[%0d]: got %b want 0", i, req_ready); end
            tick(acc, cons, w);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(acc, cons, w);
            if (acc) begin got5 = 1; req_valid = 1'b0; end
            if (cons) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
                tests_run++; if (w !== e) begin failed++; $display("FAIL full_order: got %h want %h", w, e); end
            end
        end
        req_valid = 1'b0;
        tests_run++; if (!got5) begin failed++; $display("FAIL full_fifth: got not accepted want accepted"); end
        tests_run++; if (exp_q.size() != 0) begin failed++; $display("FAIL full_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_ldi16(input logic [3:0] rd, input logic [15:0] v,
                              input logic [19:0] first_w, input int want_words);
        logic acc, cons;
        logic [19:0] w, e;
        int n = 0;
        bit first = 1;
        exp_q.delete();
        instr_ready = 1'b1;
        set_req(4'd15, rd, 4'($urandom), v);
        tick(acc, cons, w);
        req_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(acc, cons, w);
            if (cons) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
                tests_run++; if (w !== e) begin failed++; $display("FAIL ldi_word[%0d]: got %h want %h", n, w, e); end
                if (first) begin
                    tests_run++; if (w !== first_w) begin failed++; $display("FAIL ldi_movi: got %h want %h", w, first_w); end
                    first = 0;
                end
                n++;
            end
        end
        tests_run++; if (n != want_words) begin failed++; $display("FAIL ldi_count: got %0d want %0d", n, want_words); end
        tests_run++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failed++; $display("FAIL ldi_idle: got busy=%b v=%b want 0 0", busy, instr_valid); end
    endtask

    task automatic test_back_to_back;
        logic acc, cons;
        logic [19:0] w, e;
        int bubbles = 0;
        exp_q.delete();
        instr_ready = 1'b0;
        push_req(4'd15, 4'($urandom), 4'($urandom), 16'($urandom));
        push_req(4'd15, 4'($urandom), 4'($urandom), 16'($urandom));
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            tick(acc, cons, w);
            if (!cons) bubbles++;
            else begin
                e = exp_q.pop_front();
                tests_run++; if (w !== e) begin failed++; $display("FAIL b2b_word: got %h want %h", w, e); end
            end
        end
        tests_run++; if (bubbles != 0) begin failed++; $display("FAIL b2b_bubble: got %0d idle cycles want 0", bubbles); end
        tests_run++; if (exp_q.size() != 0) begin failed++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
        tick(acc, cons, w);
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_random;
        logic acc, cons;
        logic [19:0] w, e;
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            if (!req_valid || req_ready) begin
                if ($urandom_range(0, 9) < 6)
                    set_req(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 16'($urandom));
                else
                    req_valid = 1'b0;
            end
            instr_ready = ($urandom_range(0, 9) < 7);
            tick(acc, cons, w);
            if (cons) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
                tests_run++; if (w !== e) begin failed++; $display("FAIL rand_word[%0d]: got %h want %h", i, w, e); end
            end
        end
        req_valid = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 200 && busy; i++) begin
            tick(acc, cons, w);
            if (cons) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
                tests_run++; if (w !== e) begin failed++; $display("FAIL rand_drain_word: got %h want %h", w, e); end
            end
        end
        tests_run++; if (exp_q.size() != 0 || busy !== 1'b0) begin failed++; $display("FAIL rand_end: got left=%0d busy=%b want 0 0", exp_q.size(), busy); end
    endtask

    task automatic test_reset_mid;
        logic acc, cons;
        logic [19:0] w, e;
        int seen = 0;
        exp_q.delete();
        instr_ready = 1'b0;
        push_req(4'd15, 4'($urandom), 4'($urandom), 16'($urandom));
        push_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 16'($urandom));
        push_req(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom), 16'($urandom));
        instr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(acc, cons, w);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            tests_run++; if (!cons || w !== e) begin failed++; $display("FAIL rmid_word[%0d]: got cons=%b %h want %h", i, cons, w, e); end
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rmid_valid: got %b want 0", instr_valid); end
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy: got %b want 0", busy); end
        @(posedge Clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            tick(acc, cons, w);
            if (instr_valid) seen++;
        end
        tests_run++; if (seen != 0) begin failed++; $display("FAIL rmid_after: got %0d words want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_hold();
        test_fifo_full();
        test_ldi16(4'd7, 16'hA1B2, 20'h0D70A, 7);
        test_ldi16(4'd1, 16'h1200, 20'h0D101, SKIP_ZERO ? 5 : 7);
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
